proc_seq_ctrl: RTL and testbench

- Multi-cycle fetch/decode/execute controller for the simple processor.
- Drives the 5-bit address of the combinational instruction ROM and latches the 23-bit instruction word.
- Decodes the opcode and sequences register-file read/write, the write-data mux and the ALU.
- Sits between the instruction ROM and the register file/ALU datapath; `Run` and `Done` go to top level.

---
 rtl/proc_seq_ctrl.sv | 237 +++++++++++++++++++++++
 tb/tb_proc_seq_ctrl.sv | 310 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/proc_seq_ctrl.sv
// -----------------------------------------------------------------------------
// proc_seq_ctrl
//
// Multi-cycle fetch/decode/execute sequencer for the simple processor. It
// drives the program counter to a combinational instruction ROM, latches the
// returned instruction word, and sequences register-file reads and writes,
// the write-data mux and the ALU for the four-opcode instruction set:
//   0000 HALT   0001 LOAD rx<-imm   0010 MOV rx<-ry   0011 ADD rx<-rx+ry
//   0100..1111 illegal (skipped, sticky 'illegal' flag raised)
//
// Instruction layout: {op[22:19], rx[18:16], imm[15:0]}, ry = code[15:13].
//
// Ports:
//   Clock       in   system clock, rising edge
//   Resetn      in   asynchronous active-low reset
//   Run         in   level start request, sampled only in IDLE and HALT
//   step        in   single-step request (only with PROC_SEQ_CTRL_STEP_EN)
//   code_in     in   instruction word from ROM (combinational in rom_addr)
//   rom_addr    out  program counter
//   rf_raddr_x  out  register-file read port X address (rx)
//   rf_raddr_y  out  register-file read port Y address (ry)
//   rf_waddr    out  register-file write address (always rx)
//   rf_we       out  register-file write enable, one-cycle pulse
//   wr_sel      out  write-data mux select: 00 imm, 01 port Y, 10 ALU result
//   imm_out     out  immediate field of the latched instruction
//   alu_op      out  00 pass, 01 add
//   alu_ld      out  ALU result-register load strobe
//   busy        out  high in FETCH/DECODE/EXEC/WB
//   Done        out  high in HALT
//   illegal     out  sticky: an undefined opcode was encountered
//
// Optional feature, macro PROC_SEQ_CTRL_STEP_EN: adds the 'step' input and a
// PAUSE state entered after every executed or skipped instruction. PAUSE
// leaves to FETCH once per rising transition of 'step'.
// -----------------------------------------------------------------------------
module proc_seq_ctrl #(
    parameter int ADDR_W = 5,
    parameter int CODE_W = 23,
    parameter int DATA_W = 16
) (
    input  logic              Clock,
    input  logic              Resetn,
    input  logic              Run,
`ifdef PROC_SEQ_CTRL_STEP_EN
    input  logic              step,
`endif
    input  logic [CODE_W-1:0] code_in,
    output logic [ADDR_W-1:0] rom_addr,
    output logic [2:0]        rf_raddr_x,
    output logic [2:0]        rf_raddr_y,
    output logic [2:0]        rf_waddr,
    output logic              rf_we,
    output logic [1:0]        wr_sel,
    output logic [DATA_W-1:0] imm_out,
    output logic [1:0]        alu_op,
    output logic              alu_ld,
    output logic              busy,
    output logic              Done,
    output logic              illegal
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_FETCH,
        S_DECODE,
        S_EXEC,
        S_WB,
`ifdef PROC_SEQ_CTRL_STEP_EN
        S_PAUSE,
`endif
        S_HALT
    } state_t;

    localparam logic [3:0] OP_HALT = 4'b0000;
    localparam logic [3:0] OP_LOAD = 4'b0001;
    localparam logic [3:0] OP_MOV  = 4'b0010;
    localparam logic [3:0] OP_ADD  = 4'b0011;

    localparam logic [1:0] SEL_IMM = 2'b00;
    localparam logic [1:0] SEL_Y   = 2'b01;
    localparam logic [1:0] SEL_ALU = 2'b10;

    // Where the sequencer goes once an instruction has completed or been skipped.
`ifdef PROC_SEQ_CTRL_STEP_EN
    localparam state_t S_AFTER = S_PAUSE;
`else
    localparam state_t S_AFTER = S_FETCH;
`endif

    state_t            state;
    state_t            state_nxt;
    logic [ADDR_W-1:0] pc;
    logic [CODE_W-1:0] ir;
    logic [3:0]        op;
    logic [3:0]        op_nxt;
    logic              op_illegal;

    logic              rf_we_nxt;
    logic [1:0]        wr_sel_nxt;
    logic [1:0]        alu_op_nxt;
    logic              alu_ld_nxt;
    logic              busy_nxt;
    logic              done_nxt;

`ifdef PROC_SEQ_CTRL_STEP_EN
    // Set once a step request has released PAUSE; cleared when step drops, so
    // a held step advances exactly one instruction.
    logic              step_used;
    logic              step_go;
    assign step_go = step && !step_used;
`endif

    // Instruction fields come straight from the IR, which is stable from
    // FETCH exit until the next FETCH.
    assign op         = ir[CODE_W-1 -: 4];
    assign op_illegal = (op > OP_ADD);
    assign rom_addr   = pc;
    assign rf_raddr_x = ir[CODE_W-5 -: 3];
    assign rf_raddr_y = ir[DATA_W-1 -: 3];
    assign rf_waddr   = ir[CODE_W-5 -: 3];
    assign imm_out    = ir[DATA_W-1:0];

    // Opcode of the instruction that will be in the IR next cycle; the
    // registered Moore outputs are decoded from the next state and this.
    assign op_nxt = (state == S_FETCH) ? code_in[CODE_W-1 -: 4] : op;

    always_comb begin
        // NOTE: every signal gets a default before the case so no path leaves
        // it unassigned; otherwise synthesis infers a latch.
        state_nxt = state;
        unique case (state)
            S_IDLE:   if (Run) state_nxt = S_FETCH;
            S_FETCH:  state_nxt = S_DECODE;
            S_DECODE: begin
                if (op == OP_HALT)  state_nxt = S_HALT;
                else if (op_illegal) state_nxt = S_AFTER;
                else                 state_nxt = S_EXEC;
            end
            S_EXEC:   state_nxt = (op == OP_ADD) ? S_WB : S_AFTER;
            S_WB:     state_nxt = S_AFTER;
`ifdef PROC_SEQ_CTRL_STEP_EN
            S_PAUSE:  if (step_go) state_nxt = S_FETCH;
`endif
            S_HALT:   if (!Run) state_nxt = S_IDLE;
            default:  state_nxt = S_IDLE;
        endcase
    end

    always_comb begin
        rf_we_nxt  = 1'b0;
        wr_sel_nxt = SEL_IMM;
        alu_op_nxt = 2'b00;
        alu_ld_nxt = 1'b0;
        busy_nxt   = 1'b0;
        done_nxt   = 1'b0;
        case (state_nxt)
            S_FETCH, S_DECODE: busy_nxt = 1'b1;
            S_EXEC: begin
                busy_nxt = 1'b1;
                case (op_nxt)
                    OP_LOAD: begin
                        rf_we_nxt  = 1'b1;
                        wr_sel_nxt = SEL_IMM;
                    end
                    OP_MOV: begin
                        rf_we_nxt  = 1'b1;
                        wr_sel_nxt = SEL_Y;
                    end
                    OP_ADD: begin
                        alu_op_nxt = 2'b01;
                        alu_ld_nxt = 1'b1;
                    end
                    default: ;
                endcase
            end
            S_WB: begin
                busy_nxt   = 1'b1;
                rf_we_nxt  = 1'b1;
                wr_sel_nxt = SEL_ALU;
            end
            S_HALT:  done_nxt = 1'b1;
            default: ;
        endcase
    end

    // Outputs are registered and cleared by the asynchronous reset, so an
    // in-flight rf_we drops the moment Resetn falls.
    always_ff @(posedge Clock or negedge Resetn) begin
        if (!Resetn) begin
            // NOTE: state uses non-blocking assignments so every register
            // samples pre-edge values, independent of statement order.
            state   <= S_IDLE;
            pc      <= '0;
            ir      <= '0;
            illegal <= 1'b0;
            rf_we   <= 1'b0;
            wr_sel  <= SEL_IMM;
            alu_op  <= 2'b00;
            alu_ld  <= 1'b0;
            busy    <= 1'b0;
            Done    <= 1'b0;
        end else begin
            state  <= state_nxt;
            rf_we  <= rf_we_nxt;
            wr_sel <= wr_sel_nxt;
            alu_op <= alu_op_nxt;
            alu_ld <= alu_ld_nxt;
            busy   <= busy_nxt;
            Done   <= done_nxt;

            if (state == S_FETCH) begin
                ir <= code_in;
                pc <= pc + ADDR_W'(1);   // natural wrap 31 -> 0
            end

            if (state == S_DECODE && op_illegal)
                illegal <= 1'b1;

            if (state == S_HALT && !Run) begin
                pc      <= '0;
                illegal <= 1'b0;
            end
        end
    end

`ifdef PROC_SEQ_CTRL_STEP_EN
    always_ff @(posedge Clock or negedge Resetn) begin
        if (!Resetn)
            step_used <= 1'b0;
        else if (!step)
            step_used <= 1'b0;
        else if (state == S_PAUSE)
            step_used <= 1'b1;
    end
`endif

endmodule

// File: tb/tb_proc_seq_ctrl.sv
// -----------------------------------------------------------------------------
// Testbench for proc_seq_ctrl. A behavioural ROM feeds the DUT; register-file
// writes expected from each program are queued up front and popped by a
// monitor whenever the DUT pulses rf_we. Directed cycle-by-cycle checks cover
// reset, instruction latency, HALT/Run handling, illegal opcodes, PC wrap and
// reset in the middle of an instruction (or single-stepping when the step
// feature is built in).
// -----------------------------------------------------------------------------
module tb_proc_seq_ctrl;

    logic        Clock = 1'b0;
    logic        Resetn;
    logic        Run;
`ifdef PROC_SEQ_CTRL_STEP_EN
    logic        step;
`endif
    logic [22:0] code_in;
    logic [4:0]  rom_addr;
    logic [2:0]  rf_raddr_x;
    logic [2:0]  rf_raddr_y;
    logic [2:0]  rf_waddr;
    logic        rf_we;
    logic [1:0]  wr_sel;
    logic [15:0] imm_out;
    logic [1:0]  alu_op;
    logic        alu_ld;
    logic        busy;
    logic        Done;
    logic        illegal;

    logic [22:0] rom [32];

    int n_checks = 0;
    int n_errors = 0;

    typedef struct {
        logic [2:0]  waddr;
        logic [1:0]  sel;
        logic [2:0]  ry;
        logic [15:0] imm;
    } wr_t;

    wr_t sb[$];

    always #5 Clock = ~Clock;

    assign code_in = rom[rom_addr];

    proc_seq_ctrl dut (
        .Clock      (Clock),
        .Resetn     (Resetn),
        .Run        (Run),
`ifdef PROC_SEQ_CTRL_STEP_EN
        .step       (step),
`endif
        .code_in    (code_in),
        .rom_addr   (rom_addr),
        .rf_raddr_x (rf_raddr_x),
        .rf_raddr_y (rf_raddr_y),
        .rf_waddr   (rf_waddr),
        .rf_we      (rf_we),
        .wr_sel     (wr_sel),
        .imm_out    (imm_out),
        .alu_op     (alu_op),
        .alu_ld     (alu_ld),
        .busy       (busy),
        .Done       (Done),
        .illegal    (illegal)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, obs, exp, $time);
        end
    endtask

    function automatic logic [22:0] enc_load(input logic [2:0] rx, input logic [15:0] imm);
        return {4'b0001, rx, imm};
    endfunction

    function automatic logic [22:0] enc_mov(input logic [2:0] rx, input logic [2:0] ry);
        return {4'b0010, rx, ry, 13'h0};
    endfunction

    function automatic logic [22:0] enc_add(input logic [2:0] rx, input logic [2:0] ry);
        return {4'b0011, rx, ry, 13'h0};
    endfunction

    // Reference model: what register-file write (if any) an instruction causes.
    task automatic push_expect(input logic [22:0] code);
        wr_t e;
        e.waddr = code[18:16];
        e.ry    = code[15:13];
        e.imm   = code[15:0];
        case (code[22:19])
            4'b0001: begin e.sel = 2'b00; sb.push_back(e); end
            4'b0010: begin e.sel = 2'b01; sb.push_back(e); end
            4'b0011: begin e.sel = 2'b10; sb.push_back(e); end
            default: ;
        endcase
    endtask

    task automatic clear_rom();
        for (int i = 0; i < 32; i++) rom[i] = '0;
    endtask

    task automatic tick();
        @(negedge Clock);
    endtask

    // Scoreboard monitor: every write pulse must match the oldest expected write.
    always @(negedge Clock) begin
        if (Resetn === 1'b1 && rf_we === 1'b1) begin
            if (sb.size() == 0) begin
                check("sb_unexpected_write", 32'(rf_waddr), 32'hFFFF_FFFF);
            end else begin
                wr_t e;
                e = sb.pop_front();
                check("sb_waddr", 32'(rf_waddr), 32'(e.waddr));
                check("sb_sel", 32'(wr_sel), 32'(e.sel));
                check("sb_busy", 32'(busy), 32'd1);
                if (e.sel == 2'b00) check("sb_imm", 32'(imm_out), 32'(e.imm));
                if (e.sel == 2'b01) check("sb_ry", 32'(rf_raddr_y), 32'(e.ry));
                if (e.sel == 2'b10) check("sb_rx_src", 32'(rf_raddr_x), 32'(e.waddr));
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not end, got timeout expected finish");
        $fatal(1, "watchdog");
    end

    task automatic load_prog_a();
        clear_rom();
        rom[0] = enc_load(3'd1, 16'h0009);
        rom[1] = enc_mov(3'd5, 3'd7);
        rom[2] = enc_add(3'd3, 3'd0);
        rom[3] = 23'h0;
        for (int i = 0; i < 4; i++) push_expect(rom[i]);
    endtask

    initial begin
        Resetn = 1'b0;
        Run    = 1'b0;
`ifdef PROC_SEQ_CTRL_STEP_EN
        step   = 1'b0;
`endif
        clear_rom();
        repeat (2) tick();
        check("rst_rom_addr", 32'(rom_addr), 0);
        check("rst_rf_we", 32'(rf_we), 0);
        check("rst_busy", 32'(busy), 0);
        check("rst_done", 32'(Done), 0);
        check("rst_illegal", 32'(illegal), 0);
        check("rst_imm", 32'(imm_out), 0);
        check("rst_wr_sel", 32'(wr_sel), 0);
        check("rst_alu", 32'({alu_op, alu_ld}), 0);
        Resetn = 1'b1;
        tick();
        check("idle_busy", 32'(busy), 0);

`ifdef PROC_SEQ_CTRL_STEP_EN
        // ---- single-step: PAUSE after each instruction ----
        load_prog_a();
        Run = 1'b1;
        tick(); check("s_fetch_busy", 32'(busy), 1);
        tick(); check("s_dec_pc", 32'(rom_addr), 1);
        tick(); check("s_ld_we", 32'(rf_we), 1);
        for (int i = 0; i < 10; i++) begin
            tick();
            check("s_pause_pc", 32'(rom_addr), 1);
            check("s_pause_busy", 32'(busy), 0);
            check("s_pause_we", 32'(rf_we), 0);
        end
        step = 1'b1;
        tick(); check("s_step_fetch", 32'(busy), 1);
        tick(); check("s_step_dec_pc", 32'(rom_addr), 2);
        tick(); check("s_mov_we", 32'(rf_we), 1);
        for (int i = 0; i < 4; i++) begin
            tick();
            check("s_held_pc", 32'(rom_addr), 2);
            check("s_held_busy", 32'(busy), 0);
        end
        step = 1'b0;
        tick();
        step = 1'b1;
        tick(); check("s_add_fetch", 32'(busy), 1);
        tick(); tick();
        check("s_add_alu_ld", 32'(alu_ld), 1);
        tick(); check("s_add_wb", 32'(wr_sel), 2);
        tick();
        check("s_add_pause_pc", 32'(rom_addr), 3);
        check("s_add_pause_busy", 32'(busy), 0);
        check("s_sb_drain", 32'(sb.size()), 0);
`else
        // ---- program A: LOAD, MOV, ADD, HALT ----
        load_prog_a();
        Run = 1'b1;
        tick(); check("a_fetch_busy", 32'(busy), 1);
                check("a_fetch_pc", 32'(rom_addr), 0);
        tick(); check("a_dec_pc", 32'(rom_addr), 1);
                check("a_dec_rx", 32'(rf_raddr_x), 1);
                check("a_dec_we", 32'(rf_we), 0);
        tick(); check("a_ld_we", 32'(rf_we), 1);
                check("a_ld_imm", 32'(imm_out), 32'h9);
        tick(); check("a_f2_we", 32'(rf_we), 0);
                check("a_f2_pc", 32'(rom_addr), 1);
        Run = 1'b0;   // must not stop a running program
        tick(); check("a_dec_mov_pc", 32'(rom_addr), 2);
        tick(); check("a_mov_we", 32'(rf_we), 1);
                check("a_mov_ry", 32'(rf_raddr_y), 7);
                check("a_mov_wa", 32'(rf_waddr), 5);
                check("a_mov_sel", 32'(wr_sel), 1);
        tick(); check("a_f3_busy", 32'(busy), 1);
                check("a_f3_we", 32'(rf_we), 0);
        Run = 1'b1;
        tick(); check("a_dec_add_x", 32'(rf_raddr_x), 3);
                check("a_dec_add_y", 32'(rf_raddr_y), 0);
        tick(); check("a_add_aluop", 32'(alu_op), 1);
                check("a_add_aluld", 32'(alu_ld), 1);
                check("a_add_we", 32'(rf_we), 0);
        tick(); check("a_wb_we", 32'(rf_we), 1);
                check("a_wb_sel", 32'(wr_sel), 2);
                check("a_wb_wa", 32'(rf_waddr), 3);
                check("a_wb_aluld", 32'(alu_ld), 0);
        tick(); check("a_f4_pc", 32'(rom_addr), 3);
                check("a_f4_busy", 32'(busy), 1);
        tick(); check("a_dec_halt_pc", 32'(rom_addr), 4);
        tick(); check("a_halt_done", 32'(Done), 1);
                check("a_halt_busy", 32'(busy), 0);
        for (int i = 0; i < 5; i++) begin
            tick();
            check("a_hold_done", 32'(Done), 1);
            check("a_hold_pc", 32'(rom_addr), 4);
        end
        Run = 1'b0;
        tick(); check("a_idle_done", 32'(Done), 0);
                check("a_idle_pc", 32'(rom_addr), 0);
                check("a_idle_busy", 32'(busy), 0);
        check("a_sb_drain", 32'(sb.size()), 0);

        // ---- program C: illegal then HALT; HALT exit clears the flag ----
        clear_rom();
        rom[0] = {4'b0111, 3'd2, 16'h1234};
        rom[1] = 23'h0;
        Run = 1'b1;
        tick(); tick();
        check("c_dec_illegal", 32'(illegal), 0);
        tick(); check("c_skip_illegal", 32'(illegal), 1);
                check("c_skip_pc", 32'(rom_addr), 1);
                check("c_skip_busy", 32'(busy), 1);
        tick();
        tick(); check("c_halt_done", 32'(Done), 1);
                check("c_halt_illegal", 32'(illegal), 1);
        Run = 1'b0;
        tick(); check("c_idle_illegal", 32'(illegal), 0);
                check("c_idle_pc", 32'(rom_addr), 0);

        // ---- program B: 31 LOADs + illegal at 5, wrap, reset mid-EXEC ----
        clear_rom();
        for (int i = 0; i < 32; i++)
            rom[i] = enc_load(3'(i), 16'h1000 + 16'(i));
        rom[5] = {4'b0111, 3'd6, 16'hBEEF};
        for (int i = 0; i < 32; i++) push_expect(rom[i]);
        push_expect(rom[0]);
        Run = 1'b1;
        for (int t = 1; t <= 98; t++) begin
            tick();
            if (t == 17) begin
                check("b_dec_ill_pc", 32'(rom_addr), 6);
                check("b_dec_ill_flag", 32'(illegal), 0);
                check("b_dec_ill_we", 32'(rf_we), 0);
            end
            if (t == 18) begin
                check("b_ill_next_pc", 32'(rom_addr), 6);
                check("b_ill_flag", 32'(illegal), 1);
                check("b_ill_we", 32'(rf_we), 0);
            end
            if (t == 94) check("b_wrap_pc", 32'(rom_addr), 0);
            if (t == 95) check("b_sticky_ill", 32'(illegal), 1);
            if (t == 98) begin
                check("b_wrap_exec_we", 32'(rf_we), 1);
                check("b_wrap_exec_imm", 32'(imm_out), 32'h1000);
            end
        end
        #2 Resetn = 1'b0;
        #1;
        check("b_rst_we_async", 32'(rf_we), 0);
        check("b_rst_busy", 32'(busy), 0);
        check("b_rst_pc", 32'(rom_addr), 0);
        Run = 1'b0;
        tick();
        Resetn = 1'b1;
        tick();
        check("b_post_rst_pc", 32'(rom_addr), 0);
        check("b_post_rst_done", 32'(Done), 0);
        check("b_post_rst_busy", 32'(busy), 0);
        check("b_post_rst_ill", 32'(illegal), 0);
        check("b_sb_drain", 32'(sb.size()), 0);
`endif

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
